// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every signal between the two requesters, the arbiter and the
// single-ported Memory block.
//   requester side : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 (to arbiter)
//                    ack0/ack1, err0/err1, rdata, busy (from arbiter)
//   memory side    : mem_Address, mem_DataIn, mem_memRead, mem_memWrite (from arbiter)
//                    mem_DataOut (from Memory)
// The slave modport is the arbiter's view. The master modport is the view of
// whoever plays both requesters and the Memory.
interface mem_arbiter_if #(
   parameter int n = 64
);
   logic         req0;
   logic         req1;
   logic         we0;
   logic         we1;
   logic [n-1:0] addr0;
   logic [n-1:0] addr1;
   logic [n-1:0] wdata0;
   logic [n-1:0] wdata1;
   logic         ack0;
   logic         ack1;
   logic         err0;
   logic         err1;
   logic [n-1:0] rdata;
   logic         busy;
   logic [n-1:0] mem_Address;
   logic [n-1:0] mem_DataIn;
   logic         mem_memRead;
   logic         mem_memWrite;
   logic [n-1:0] mem_DataOut;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_DataOut,
      output ack0, ack1, err0, err1, rdata, busy,
             mem_Address, mem_DataIn, mem_memRead, mem_memWrite
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_DataOut,
      input  ack0, ack1, err0, err1, rdata, busy,
             mem_Address, mem_DataIn, mem_memRead, mem_memWrite
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-port round-robin arbiter in front of a single-ported Memory. Port 0 is
// instruction fetch, port 1 is load/store. Each access takes one GRANT cycle
// in which the registered memory strobes are driven, followed by one ACK cycle
// in which the winning port sees its ack (with err) and any read data.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : mem_arbiter_if slave view (requests, acks, rdata, busy, Memory pins)
module mem_arbiter #(
   parameter int n        = 64,
   parameter int log2Size = 10
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ACK
   } state_t;

   state_t       state_q, state_d;
   logic         last_q, last_d;
   logic         port_q, port_d;
   logic         we_q, we_d;
   logic         oor_q, oor_d;
   logic [n-1:0] memAddress_q, memAddress_d;
   logic [n-1:0] memDataIn_q, memDataIn_d;
   logic         memRead_q, memRead_d;
   logic         memWrite_q, memWrite_d;
   logic         ack0_q, ack0_d;
   logic         ack1_q, ack1_d;
   logic         err0_q, err0_d;
   logic         err1_q, err1_d;
   logic [n-1:0] rdata_q, rdata_d;

   logic         selValid;
   logic         selPort;
   logic         selWe;
   logic         selOor;
   logic [n-1:0] selAddr;
   logic [n-1:0] selWdata;

   // Pick the next access. In IDLE a lone requester wins and a tie goes to the
   // port that was not granted last. In ACK only the other port may be picked,
   // which is exactly the round-robin winner, so the acked port cannot starve it.
   always_comb begin
      selValid = 1'b0;
      selPort  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               selValid = 1'b1;
               selPort  = ~last_q;
            end else if (bus.req0) begin
               selValid = 1'b1;
               selPort  = 1'b0;
            end else if (bus.req1) begin
               selValid = 1'b1;
               selPort  = 1'b1;
            end
         end
         ACK: begin
            if (!port_q && bus.req1) begin
               selValid = 1'b1;
               selPort  = 1'b1;
            end else if (port_q && bus.req0) begin
               selValid = 1'b1;
               selPort  = 1'b0;
            end
         end
         default: begin
         end
      endcase
      selWe    = selPort ? bus.we1 : bus.we0;
      selAddr  = selPort ? bus.addr1 : bus.addr0;
      selWdata = selPort ? bus.wdata1 : bus.wdata0;
      selOor   = (selAddr[n-1:log2Size] != '0);
   end

   // Next-state and registered outputs. Memory strobes and acks default to 0
   // so they are high only for the single cycle after the edge that sets them;
   // the memory pins are loaded on the edge entering GRANT and cleared on the
   // edge leaving it, and out-of-range accesses never touch the memory.
   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      port_d       = port_q;
      we_d         = we_q;
      oor_d        = oor_q;
      memAddress_d = '0;
      memDataIn_d  = '0;
      memRead_d    = 1'b0;
      memWrite_d   = 1'b0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err0_d       = 1'b0;
      err1_d       = 1'b0;
      rdata_d      = rdata_q;
      case (state_q)
         IDLE, ACK: begin
            if (selValid) begin
               state_d = GRANT;
               last_d  = selPort;
               port_d  = selPort;
               we_d    = selWe;
               oor_d   = selOor;
               if (!selOor) begin
                  memAddress_d = selAddr;
                  memDataIn_d  = selWe ? selWdata : '0;
                  memRead_d    = ~selWe;
                  memWrite_d   = selWe;
               end
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            state_d = ACK;
            ack0_d  = ~port_q;
            ack1_d  = port_q;
            err0_d  = ~port_q & oor_q;
            err1_d  = port_q & oor_q;
            if (oor_q) begin
               rdata_d = '0;
            end else if (!we_q) begin
               rdata_d = bus.mem_DataOut;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset clears the memory strobes asynchronously so a
   // write caught mid-GRANT never reaches the memory's clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         oor_q        <= 1'b0;
         memAddress_q <= '0;
         memDataIn_q  <= '0;
         memRead_q    <= 1'b0;
         memWrite_q   <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         err1_q       <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         port_q       <= port_d;
         we_q         <= we_d;
         oor_q        <= oor_d;
         memAddress_q <= memAddress_d;
         memDataIn_q  <= memDataIn_d;
         memRead_q    <= memRead_d;
         memWrite_q   <= memWrite_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err0_q       <= err0_d;
         err1_q       <= err1_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bus.ack0         = ack0_q;
   assign bus.ack1         = ack1_q;
   assign bus.err0         = err0_q;
   assign bus.err1         = err1_q;
   assign bus.rdata        = rdata_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.mem_Address  = memAddress_q;
   assign bus.mem_DataIn   = memDataIn_q;
   assign bus.mem_memRead  = memRead_q;
   assign bus.mem_memWrite = memWrite_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives two requesters plus a behavioural Memory and compares every cycle
// against a transaction-level model: each access is predicted to ack exactly
// two cycles after it is picked, ties go to the port not served last, a port
// waiting during another's ack is served next, and rdata follows a reference
// copy of the memory.
module tb_mem_arbiter;

   localparam int N        = 64;
   localparam int LOG2SIZE = 10;
   localparam int SIZE     = 1 << LOG2SIZE;

   typedef struct packed {
      logic         we;
      logic [N-1:0] addr;
      logic [N-1:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic reset;
   logic memInit;

   always #5 clk = ~clk;

   mem_arbiter_if #(.n(N)) bus ();

   mem_arbiter #(.n(N), .log2Size(LOG2SIZE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [N-1:0] initWord(input int i);
      return (64'(i) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   // Behavioural Memory: combinational read, posedge write.
   logic [N-1:0] memArray [SIZE];
   always @(posedge clk) begin
      if (memInit) begin
         for (int i = 0; i < SIZE; i++) memArray[i] <= initWord(i);
      end else if (bus.mem_memWrite) begin
         memArray[bus.mem_Address[LOG2SIZE-1:0]] <= bus.mem_DataIn;
      end
   end
   assign bus.mem_DataOut = memArray[bus.mem_Address[LOG2SIZE-1:0]];

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   txn_t queue0[$];
   txn_t queue1[$];
   txn_t curTxn [2];
   bit   reqActive [2];
   bit   randomMode;

   bit           active;
   int           expCycle;
   int           expPort;
   int           lastPort;
   txn_t         grantTxn;
   logic [N-1:0] refRdata;
   logic [N-1:0] refMem [SIZE];
   logic [N-1:0] lastAckRdata;
   logic         lastAckErr;
   int           ackPortLog[$];
   int           ackCycleLog[$];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h, expected %h (cycle %0d)", tag, observed, expected, cycle);
      end
   endtask

   function automatic txn_t randomTxn();
      txn_t t;
      t.we    = 1'($urandom_range(1, 0));
      t.wdata = {32'($urandom), 32'($urandom)};
      case ($urandom_range(9, 0))
         0:       t.addr = 64'(SIZE + $urandom_range(4000, 0));
         1:       t.addr = {32'($urandom) | 32'h1, 32'($urandom)};
         default: t.addr = 64'($urandom_range(15, 0));
      endcase
      return t;
   endfunction

   function automatic txn_t mkTxn(input logic we, input logic [N-1:0] addr, input logic [N-1:0] wdata);
      txn_t t;
      t.we    = we;
      t.addr  = addr;
      t.wdata = wdata;
      return t;
   endfunction

   task automatic driveBus();
      bus.req0   = reqActive[0];
      bus.we0    = curTxn[0].we;
      bus.addr0  = curTxn[0].addr;
      bus.wdata0 = curTxn[0].wdata;
      bus.req1   = reqActive[1];
      bus.we1    = curTxn[1].we;
      bus.addr1  = curTxn[1].addr;
      bus.wdata1 = curTxn[1].wdata;
   endtask

   // Idle ports take the next queued transaction (random mode refills queues).
   task automatic applyStimulus();
      if (!reqActive[0]) begin
         if (randomMode && queue0.size() == 0 && $urandom_range(1, 0) == 1) queue0.push_back(randomTxn());
         if (queue0.size() != 0) begin
            curTxn[0]    = queue0.pop_front();
            reqActive[0] = 1'b1;
         end
      end
      if (!reqActive[1]) begin
         if (randomMode && queue1.size() == 0 && $urandom_range(1, 0) == 1) queue1.push_back(randomTxn());
         if (queue1.size() != 0) begin
            curTxn[1]    = queue1.pop_front();
            reqActive[1] = 1'b1;
         end
      end
      driveBus();
   endtask

   task automatic scheduleAccess(input int p);
      active   = 1'b1;
      expPort  = p;
      expCycle = cycle + 2;
      grantTxn = curTxn[p];
      lastPort = p;
   endtask

   // Decide which access the requests driven for the coming edge start.
   task automatic updateModel();
      if (active && cycle == expCycle) begin
         if (reqActive[1 - expPort]) scheduleAccess(1 - expPort);
         else active = 1'b0;
      end else if (!active) begin
         if (reqActive[0] && reqActive[1]) scheduleAccess(1 - lastPort);
         else if (reqActive[0]) scheduleAccess(0);
         else if (reqActive[1]) scheduleAccess(1);
      end
   endtask

   task automatic checkCycle();
      bit inGrant;
      bit isAck;
      bit inRng;
      inGrant = active && (cycle == expCycle - 1);
      isAck   = active && (cycle == expCycle);
      inRng   = (grantTxn.addr >> LOG2SIZE) == '0;
      if (bus.ack0) begin ackPortLog.push_back(0); ackCycleLog.push_back(cycle); end
      if (bus.ack1) begin ackPortLog.push_back(1); ackCycleLog.push_back(cycle); end
      checkOutput("ack0", 64'(bus.ack0), 64'(isAck && expPort == 0));
      checkOutput("ack1", 64'(bus.ack1), 64'(isAck && expPort == 1));
      checkOutput("busy", 64'(bus.busy), 64'(inGrant || isAck));
      checkOutput("memRead", 64'(bus.mem_memRead), 64'(inGrant && inRng && !grantTxn.we));
      checkOutput("memWrite", 64'(bus.mem_memWrite), 64'(inGrant && inRng && grantTxn.we));
      if (inGrant && inRng) begin
         checkOutput("memAddress", bus.mem_Address, grantTxn.addr);
         if (grantTxn.we) checkOutput("memDataIn", bus.mem_DataIn, grantTxn.wdata);
      end else if (!inGrant) begin
         checkOutput("memAddressIdle", bus.mem_Address, 64'(0));
         checkOutput("memDataInIdle", bus.mem_DataIn, 64'(0));
      end
      if (isAck) begin
         if (!inRng) refRdata = '0;
         else if (!grantTxn.we) refRdata = refMem[grantTxn.addr[LOG2SIZE-1:0]];
         else refMem[grantTxn.addr[LOG2SIZE-1:0]] = grantTxn.wdata;
         checkOutput(expPort == 0 ? "err0" : "err1", 64'(expPort == 0 ? bus.err0 : bus.err1), 64'(!inRng));
         lastAckRdata       = bus.rdata;
         lastAckErr         = (expPort == 0) ? bus.err0 : bus.err1;
         reqActive[expPort] = 1'b0;
      end
      checkOutput("rdata", bus.rdata, refRdata);
   endtask

   task automatic checkResetState();
      checkOutput("rstAck0", 64'(bus.ack0), 64'(0));
      checkOutput("rstAck1", 64'(bus.ack1), 64'(0));
      checkOutput("rstErr", 64'(bus.err0 | bus.err1), 64'(0));
      checkOutput("rstBusy", 64'(bus.busy), 64'(0));
      checkOutput("rstMemRead", 64'(bus.mem_memRead), 64'(0));
      checkOutput("rstMemWrite", 64'(bus.mem_memWrite), 64'(0));
      checkOutput("rstMemAddress", bus.mem_Address, 64'(0));
      checkOutput("rstMemDataIn", bus.mem_DataIn, 64'(0));
      checkOutput("rstRdata", bus.rdata, 64'(0));
   endtask

   task automatic waitNeg();
      @(negedge clk);
      cycle++;
   endtask

   task automatic stepCycle();
      waitNeg();
      checkCycle();
      applyStimulus();
      updateModel();
   endtask

   task automatic runUntilDrained(input int maxCycles);
      int n = 0;
      while ((queue0.size() != 0 || queue1.size() != 0 || reqActive[0] || reqActive[1] || active) && n < maxCycles) begin
         stepCycle();
         n++;
      end
      checkOutput("drainOutstanding", 64'(queue0.size() + queue1.size() + int'(reqActive[0]) + int'(reqActive[1]) + int'(active)), 64'(0));
   endtask

   task automatic resetModel();
      active       = 1'b0;
      lastPort     = 1;
      refRdata     = '0;
      reqActive[0] = 1'b0;
      reqActive[1] = 1'b0;
      queue0.delete();
      queue1.delete();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int releaseCycle;
      int issueCycle;
      bool_found: begin end
      reset      = 1'b1;
      memInit    = 1'b1;
      randomMode = 1'b0;
      curTxn[0]  = '0;
      curTxn[1]  = '0;
      resetModel();
      for (int i = 0; i < SIZE; i++) refMem[i] = initWord(i);
      driveBus();

      // Reset with both ports requesting; first grant must go to port 0.
      queue0.push_back(mkTxn(1'b0, 64'd3, 64'd0));
      queue1.push_back(mkTxn(1'b0, 64'd4, 64'd0));
      applyStimulus();
      repeat (3) begin
         waitNeg();
         checkResetState();
      end
      memInit = 1'b0;
      reset   = 1'b0;
      releaseCycle = cycle;
      updateModel();
      runUntilDrained(20);
      checkOutput("firstAckPort", 64'(ackPortLog.size() > 0 ? ackPortLog[0] : -1), 64'(0));
      checkOutput("firstAckCycle", 64'(ackCycleLog.size() > 0 ? ackCycleLog[0] : -1), 64'(releaseCycle + 2));
      checkOutput("secondAckPort", 64'(ackPortLog.size() > 1 ? ackPortLog[1] : -1), 64'(1));

      // Port 1 writes DEADBEEF to 5, port 0 reads it back.
      queue1.push_back(mkTxn(1'b1, 64'd5, 64'hDEAD_BEEF));
      runUntilDrained(20);
      queue0.push_back(mkTxn(1'b0, 64'd5, 64'd0));
      runUntilDrained(20);
      checkOutput("deadbeefRdata", lastAckRdata, 64'hDEAD_BEEF);
      checkOutput("deadbeefErr", 64'(lastAckErr), 64'(0));

      // Both ports request continuously: acks alternate every 2 cycles.
      ackPortLog.delete();
      ackCycleLog.delete();
      for (int i = 0; i < 4; i++) begin
         queue0.push_back(mkTxn(1'b0, 64'(i), 64'd0));
         queue1.push_back(mkTxn(1'b0, 64'(i + 8), 64'd0));
      end
      runUntilDrained(40);
      checkOutput("altCount", 64'(ackPortLog.size()), 64'(8));
      for (int i = 0; i < ackPortLog.size(); i++) begin
         checkOutput("altPort", 64'(ackPortLog[i]), 64'((i + 1) % 2));
         if (i > 0) checkOutput("altSpacing", 64'(ackCycleLog[i] - ackCycleLog[i-1]), 64'(2));
      end

      // Out-of-range read.
      queue0.push_back(mkTxn(1'b0, 64'(SIZE), 64'd0));
      runUntilDrained(20);
      checkOutput("oorErr", 64'(lastAckErr), 64'(1));
      checkOutput("oorRdata", lastAckRdata, 64'(0));

      // Reset during the GRANT cycle of a write: it must not commit.
      queue0.push_back(mkTxn(1'b1, 64'd7, 64'h55));
      issueCycle = cycle;
      while (!(active && cycle == expCycle - 1) && cycle < issueCycle + 10) stepCycle();
      checkOutput("reachedGrant", 64'(active && cycle == expCycle - 1), 64'(1));
      reset = 1'b1;
      #1;
      checkResetState();
      resetModel();
      driveBus();
      waitNeg();
      checkResetState();
      reset = 1'b0;
      queue0.push_back(mkTxn(1'b0, 64'd7, 64'd0));
      runUntilDrained(20);
      checkOutput("afterResetRead7", lastAckRdata, initWord(7));

      // Port 0 alone, three reads back-to-back: one ack every 3 cycles.
      ackPortLog.delete();
      ackCycleLog.delete();
      for (int i = 0; i < 3; i++) queue0.push_back(mkTxn(1'b0, 64'(i + 1), 64'd0));
      runUntilDrained(30);
      checkOutput("soloCount", 64'(ackPortLog.size()), 64'(3));
      for (int i = 1; i < ackCycleLog.size(); i++)
         checkOutput("soloSpacing", 64'(ackCycleLog[i] - ackCycleLog[i-1]), 64'(3));

      // Randomized traffic.
      randomMode = 1'b1;
      repeat (3000) stepCycle();
      randomMode = 1'b0;
      runUntilDrained(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
